// File: rtl/regfile_sb_pkg.sv
// Shared defaults and constants for the register file with scoreboard.
// Imported by the interface, the bypass mux and the top level.
package regfile_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  localparam logic [DEF_DATA_W-1:0] ZERO_WORD = '0;
  localparam logic READ_ENABLE  = 1'b1;
  localparam logic WRITE_ENABLE = 1'b1;

  function automatic int num_regs(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Bus bundle between decode/issue/writeback and the register file.
// The pipeline side drives as master; the register file is the slave.
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2
);

  logic [NUM_WR-1:0]        we;
  logic [NUM_WR*ADDR_W-1:0] waddr;
  logic [NUM_WR*DATA_W-1:0] wdata;
  logic [NUM_RD-1:0]        re;
  logic [NUM_RD*ADDR_W-1:0] raddr;
  logic [NUM_RD*DATA_W-1:0] rdata;
  logic [NUM_RD-1:0]        rbusy;
  logic                     iss_valid;
  logic [ADDR_W-1:0]        iss_addr;
  logic                     flush;
  logic [ADDR_W:0]          busy_cnt;

  modport master (
    output we, waddr, wdata, re, raddr, iss_valid, iss_addr, flush,
    input  rdata, rbusy, busy_cnt
  );

  modport slave (
    input  we, waddr, wdata, re, raddr, iss_valid, iss_addr, flush,
    output rdata, rbusy, busy_cnt
  );

endinterface

// File: rtl/regfile_sb_bypass_mux.sv
// Write-to-read bypass selector for one read port.
// The highest-indexed matching write port wins.
module regfile_bypass_mux
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_WR   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic                     re,
  input  logic [ADDR_W-1:0]        raddr,
  output logic                     hit,
  output logic [DATA_W-1:0]        hdata
);

  logic zero_addr;

  assign zero_addr = ZERO_REG && (raddr == '0);

  // Ascending scan so a later (higher) port overrides an earlier match.
  always_comb begin
    hit   = 1'b0;
    hdata = DATA_W'(ZERO_WORD);
    if (re == READ_ENABLE && !zero_addr) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (we[k] == WRITE_ENABLE && waddr[k*ADDR_W +: ADDR_W] == raddr) begin
          hit   = 1'b1;
          hdata = wdata[k*DATA_W +: DATA_W];
        end
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with per-register busy bits for RAW hazard stalls.
// Reads are combinational with same-cycle write bypass; busy_cnt is registered.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int NUM_WR   = 2,
  parameter bit ZERO_REG = 1'b1
) (
  input logic        clk,
  input logic        rst,
  regfile_sb_if.slave bus
);

  localparam int NUM_REGS = num_regs(ADDR_W);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic [ADDR_W:0]     busy_cnt_q;
  logic [ADDR_W:0]     cnt_nxt;

  logic [ADDR_W-1:0]   wa     [NUM_WR];
  logic [DATA_W-1:0]   wd     [NUM_WR];
  logic [NUM_WR-1:0]   wr_ok;

  logic [ADDR_W-1:0]   ra     [NUM_RD];
  logic [NUM_RD-1:0]   hit;
  logic [DATA_W-1:0]   hdata  [NUM_RD];
  logic [NUM_RD*DATA_W-1:0] rdata_all;
  logic [NUM_RD-1:0]   rbusy_all;

  function automatic logic is_dropped(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  for (genvar k = 0; k < NUM_WR; k++) begin : g_wport
    assign wa[k]    = bus.waddr[k*ADDR_W +: ADDR_W];
    assign wd[k]    = bus.wdata[k*DATA_W +: DATA_W];
    assign wr_ok[k] = (bus.we[k] == WRITE_ENABLE) && !is_dropped(wa[k]);
  end

  // Ascending port order: the higher port's non-blocking write lands last.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wr_ok[k]) begin
          regs[wa[k]] <= wd[k];
        end
      end
    end
  end

  // Flush beats issue, issue beats writeback clear (new producer wins).
  always_comb begin
    busy_nxt = busy;
    if (bus.flush) begin
      busy_nxt = '0;
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (bus.we[k] == WRITE_ENABLE) begin
          busy_nxt[wa[k]] = 1'b0;
        end
      end
      if (bus.iss_valid) begin
        busy_nxt[bus.iss_addr] = 1'b1;
      end
      if (ZERO_REG) begin
        busy_nxt[0] = 1'b0;
      end
    end
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      cnt_nxt = cnt_nxt + {{ADDR_W{1'b0}}, busy_nxt[i]};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy       <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_cnt_q <= cnt_nxt;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rport
    assign ra[i] = bus.raddr[i*ADDR_W +: ADDR_W];

    regfile_bypass_mux #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .NUM_WR   (NUM_WR),
      .ZERO_REG (ZERO_REG)
    ) u_byp (
      .we    (bus.we),
      .waddr (bus.waddr),
      .wdata (bus.wdata),
      .re    (bus.re[i]),
      .raddr (ra[i]),
      .hit   (hit[i]),
      .hdata (hdata[i])
    );
  end

  // Outputs are forced to zero while reset is held, independent of storage.
  always_comb begin
    rdata_all = '0;
    rbusy_all = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (rst && bus.re[i] == READ_ENABLE && !is_dropped(ra[i])) begin
        if (hit[i]) begin
          rdata_all[i*DATA_W +: DATA_W] = hdata[i];
        end else begin
          rdata_all[i*DATA_W +: DATA_W] = regs[ra[i]];
          rbusy_all[i]                  = busy[ra[i]];
        end
      end
    end
  end

  assign bus.rdata    = rdata_all;
  assign bus.rbusy    = rbusy_all;
  assign bus.busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed and randomized bench for regfile_sb against a behavioural model.
module tb_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;
  localparam int NREGS = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mem [NREGS];
  bit            bsy [NREGS];
  int            cnt_m;

  regfile_sb_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW)) bus ();

  regfile_sb #(
    .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .NUM_WR(NW), .ZERO_REG(1'b1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.we = '0; bus.waddr = '0; bus.wdata = '0;
    bus.re = '0; bus.raddr = '0;
    bus.iss_valid = 1'b0; bus.iss_addr = '0; bus.flush = 1'b0;
  endtask

  task automatic wport(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.we[k] = 1'b1;
    bus.waddr[k*AW +: AW] = a;
    bus.wdata[k*DW +: DW] = d;
  endtask

  task automatic rport(input int i, input logic [AW-1:0] a);
    bus.re[i] = 1'b1;
    bus.raddr[i*AW +: AW] = a;
  endtask

  task automatic model_reset();
    for (int r = 0; r < NREGS; r++) begin
      mem[r] = '0;
      bsy[r] = 1'b0;
    end
    cnt_m = 0;
  endtask

  // Expected read result: disabled -> 0, r0 -> 0, newest matching write, else storage.
  task automatic check_reads();
    for (int i = 0; i < NR; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] ed;
      bit eb;
      bit found;
      a = bus.raddr[i*AW +: AW];
      ed = '0; eb = 1'b0; found = 1'b0;
      if (bus.re[i] && a != 0) begin
        for (int k = NW - 1; k >= 0; k--) begin
          if (!found && bus.we[k] && bus.waddr[k*AW +: AW] == a) begin
            ed = bus.wdata[k*DW +: DW];
            found = 1'b1;
          end
        end
        if (!found) begin
          ed = mem[a];
          eb = bsy[a];
        end
      end
      chk($sformatf("rdata%0d", i), 64'(bus.rdata[i*DW +: DW]), 64'(ed));
      chk($sformatf("rbusy%0d", i), 64'(bus.rbusy[i]), 64'(eb));
    end
  endtask

  task automatic model_update();
    for (int k = 0; k < NW; k++) begin
      if (bus.we[k] && bus.waddr[k*AW +: AW] != 0)
        mem[bus.waddr[k*AW +: AW]] = bus.wdata[k*DW +: DW];
    end
    if (bus.flush) begin
      for (int r = 0; r < NREGS; r++) bsy[r] = 1'b0;
    end else begin
      for (int k = 0; k < NW; k++)
        if (bus.we[k]) bsy[bus.waddr[k*AW +: AW]] = 1'b0;
      if (bus.iss_valid) bsy[bus.iss_addr] = 1'b1;
      bsy[0] = 1'b0;
    end
    cnt_m = 0;
    for (int r = 0; r < NREGS; r++) cnt_m += int'(bsy[r]);
  endtask

  // Inputs are set at the falling edge; reads checked before the rising edge.
  task automatic tick();
    #1 check_reads();
    @(posedge clk);
    model_update();
    #1 chk("busy_cnt", 64'(bus.busy_cnt), 64'(cnt_m));
    @(negedge clk);
    idle();
  endtask

  initial begin
    int saved_cnt;
    idle();
    model_reset();

    // Reset held: outputs forced to zero
    rport(0, 5'd5); rport(1, 5'd9);
    #2;
    chk("rst_rdata0", 64'(bus.rdata[0 +: DW]), 64'd0);
    chk("rst_rbusy",  64'(bus.rbusy), 64'd0);
    chk("rst_cnt",    64'(bus.busy_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    idle();

    // Write r5, then asynchronous reset mid-cycle discards it
    wport(0, 5'd5, 32'hDEADBEEF);
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd9;
    tick();
    rport(0, 5'd5);
    #1 chk("r5_written", 64'(bus.rdata[0 +: DW]), 64'hDEADBEEF);
    #1 rst = 1'b0;
    #1;
    chk("midrst_rdata", 64'(bus.rdata[0 +: DW]), 64'd0);
    chk("midrst_cnt",   64'(bus.busy_cnt), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    idle();
    rport(0, 5'd5); rport(1, 5'd9);
    #1 chk("r5_after_rst", 64'(bus.rdata[0 +: DW]), 64'd0);
    chk("r9_busy_after_rst", 64'(bus.rbusy[1]), 64'd0);
    tick();

    // Write/bypass r3
    wport(0, 5'd3, 32'h12345678); rport(0, 5'd3);
    #1 chk("bypass_r3", 64'(bus.rdata[0 +: DW]), 64'h12345678);
    tick();
    rport(0, 5'd3);
    #1 chk("stored_r3", 64'(bus.rdata[0 +: DW]), 64'h12345678);
    tick();

    // Port conflict on r7
    wport(0, 5'd7, 32'h1); wport(1, 5'd7, 32'h2); rport(1, 5'd7);
    #1 chk("conflict_byp", 64'(bus.rdata[DW +: DW]), 64'h2);
    tick();
    rport(0, 5'd7);
    #1 chk("conflict_st", 64'(bus.rdata[0 +: DW]), 64'h2);
    tick();

    // Zero register
    saved_cnt = int'(bus.busy_cnt);
    wport(0, 5'd0, 32'hFFFFFFFF); bus.iss_valid = 1'b1; bus.iss_addr = 5'd0;
    rport(0, 5'd0);
    #1 chk("r0_byp", 64'(bus.rdata[0 +: DW]), 64'd0);
    chk("r0_busy_byp", 64'(bus.rbusy[0]), 64'd0);
    tick();
    rport(0, 5'd0);
    #1 chk("r0_st", 64'(bus.rdata[0 +: DW]), 64'd0);
    chk("r0_busy", 64'(bus.rbusy[0]), 64'd0);
    chk("r0_cnt", 64'(bus.busy_cnt), 64'(saved_cnt));
    tick();

    // Scoreboard on r4
    bus.iss_valid = 1'b1; bus.iss_addr = 5'd4;
    rport(0, 5'd4);
    #1 chk("r4_not_yet_busy", 64'(bus.rbusy[0]), 64'd0);
    tick();
    rport(0, 5'd4); rport(1, 5'd4);
    #1 chk("r4_busy", 64'(bus.rbusy[1]), 64'd1);
    chk("r4_cnt1", 64'(bus.busy_cnt), 64'd1);
    tick();
    wport(1, 5'd4, 32'hA5); rport(0, 5'd4);
    #1 chk("r4_wb_busy", 64'(bus.rbusy[0]), 64'd0);
    chk("r4_wb_data", 64'(bus.rdata[0 +: DW]), 64'hA5);
    tick();
    chk("r4_cnt0", 64'(bus.busy_cnt), 64'd0);
    wport(0, 5'd4, 32'h77); bus.iss_valid = 1'b1; bus.iss_addr = 5'd4;
    tick();
    rport(0, 5'd4);
    #1 chk("r4_iss_wins", 64'(bus.rbusy[0]), 64'd1);
    tick();
    wport(0, 5'd4, 32'h78);
    tick();

    // Flush
    for (int r = 1; r <= 3; r++) begin
      bus.iss_valid = 1'b1; bus.iss_addr = AW'(r);
      tick();
    end
    chk("flush_pre_cnt", 64'(bus.busy_cnt), 64'd3);
    bus.flush = 1'b1; bus.iss_valid = 1'b1; bus.iss_addr = 5'd6;
    tick();
    chk("flush_cnt", 64'(bus.busy_cnt), 64'd0);
    rport(0, 5'd6);
    #1 chk("flush_r6", 64'(bus.rbusy[0]), 64'd0);
    tick();

    // Randomized traffic over a narrow address range to force hazards
    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < NW; k++)
        if ($urandom_range(1, 0) == 1) wport(k, AW'($urandom_range(7, 0)), $urandom);
      for (int i = 0; i < NR; i++)
        if ($urandom_range(4, 0) != 0) rport(i, AW'($urandom_range(7, 0)));
      bus.iss_valid = ($urandom_range(2, 0) == 0);
      bus.iss_addr  = AW'($urandom_range(7, 0));
      bus.flush     = ($urandom_range(19, 0) == 0);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
